// File: rtl/t08_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | t08_pkg : shared types and constants for the imem responder          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package t08_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [1:0]  FAULT_NONE     = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
    localparam logic [1:0]  FAULT_TIMEOUT  = 2'b10;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Watchdog counter is never narrower than 8 bits.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/t08_imem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | t08_imem_responder_if : instruction-memory read bus                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface t08_imem_responder_if;

    logic [31:0] mem_addr;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr,
        output mem_read,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_read,
        output mem_rdata,
        output mem_ack
    );

endinterface
`default_nettype wire

// File: rtl/t08_imem_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | t08_imem_watchdog : saturating wait counter with expiry flag         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module t08_imem_watchdog #(
    parameter int LIMIT = 255,
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != WIDTH'(LIMIT))) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Flags the cycle whose increment lands on LIMIT, so the requester sees
    // exactly LIMIT enabled cycles before it gives up.
    assign expired = enable && !clear && (r_count >= WIDTH'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/t08_imem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | t08_imem_responder : PC-to-imem fetch responder with 1-entry buffer  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module t08_imem_responder
    import t08_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = NOP_WORD,
    parameter logic [31:0] PRESTART_PC    = 32'hFFFF_FFFC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] program_counter,
    input  wire logic        invalidate,
    t08_imem_responder_if.master mem,
    output logic [31:0]      instruction,
    output logic             instr_valid,
    output logic             freeze,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_tag_valid;
    logic [31:0] r_tag;
    logic [31:0] r_data;
    logic [31:0] r_req_addr;
    logic        r_discard;
    logic [1:0]  r_fault_code;
    logic        w_hit;
    logic        w_expired;

    assign w_hit = r_tag_valid && (r_tag == program_counter);

    t08_imem_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   ((r_state != REQ) || mem.mem_ack),
        .enable  (r_state == REQ),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        instruction  = NOP_INSTR;
        instr_valid  = 1'b0;
        freeze       = 1'b0;
        fault        = 1'b0;
        fault_code   = FAULT_NONE;
        case (r_state)
            IDLE: begin
                if (program_counter == PRESTART_PC) begin
                    w_next_state = IDLE;
                end else if (program_counter[1:0] != 2'b00) begin
                    w_next_state = ERR;
                    freeze       = 1'b1;
                    fault        = 1'b1;
                    fault_code   = FAULT_MISALIGN;
                end else if (w_hit) begin
                    instruction = r_data;
                    instr_valid = 1'b1;
                end else begin
                    w_next_state = REQ;
                    freeze       = 1'b1;
                end
            end
            REQ: begin
                freeze = 1'b1;
                if (mem.mem_ack) begin
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_next_state = ERR;
                end
            end
            ERR: begin
                freeze     = 1'b1;
                fault      = 1'b1;
                fault_code = r_fault_code;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_valid  <= 1'b0;
            r_tag        <= '0;
            r_data       <= NOP_INSTR;
            r_req_addr   <= '0;
            r_discard    <= 1'b0;
            r_fault_code <= FAULT_NONE;
        end else begin
            if (r_state == IDLE) begin
                if (invalidate) begin
                    r_tag_valid <= 1'b0;
                end
                if (w_next_state == REQ) begin
                    r_req_addr <= program_counter;
                end
                if (w_next_state == ERR) begin
                    r_fault_code <= FAULT_MISALIGN;
                end
            end
            if (r_state == REQ) begin
                // A store to imem during the read makes the returning word stale.
                if (mem.mem_ack && !(r_discard || invalidate)) begin
                    r_tag       <= r_req_addr;
                    r_data      <= mem.mem_rdata;
                    r_tag_valid <= 1'b1;
                end
                if (w_next_state == ERR) begin
                    r_fault_code <= FAULT_TIMEOUT;
                end
                r_discard <= (w_next_state == REQ) ? (r_discard || invalidate) : 1'b0;
            end else begin
                r_discard <= 1'b0;
            end
        end
    end

    assign mem.mem_read = (r_state == REQ);
    assign mem.mem_addr = r_req_addr;

endmodule
`default_nettype wire
